// File: rtl/adc_flash_seq_pkg.sv
// Shared types and constants for the flash ADC conversion sequencer.
package adc_flash_seq_pkg;

   localparam int unsigned CODE_W = 3;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SAMPLE  = 3'd1,
      CONVERT = 3'd2,
      CAPTURE = 3'd3,
      WAIT    = 3'd4
   } state_t;

   // Burst sum width: one code plus headroom for 2^max_avg_log2 samples.
   function automatic int unsigned acc_width(input int unsigned max_avg_log2);
      return CODE_W + max_avg_log2;
   endfunction

   function automatic int unsigned avg_sel_width(input int unsigned max_avg_log2);
      return (max_avg_log2 == 0) ? 1 : $clog2(max_avg_log2 + 1);
   endfunction

endpackage

// File: rtl/adc_flash_seq_if.sv
// Result handshake between the sequencer and the host register interface.
interface adc_flash_seq_if
   import adc_flash_seq_pkg::*;
#(
   parameter int unsigned MAX_AVG_LOG2 = 3
);
   localparam int unsigned SUM_W = acc_width(MAX_AVG_LOG2);

   logic [CODE_W-1:0] out_code;
   logic [SUM_W-1:0]  out_sum;
   logic              out_valid;
   logic              out_ready;

   modport master (output out_code, output out_sum, output out_valid, input out_ready);
   modport slave  (input out_code, input out_sum, input out_valid, output out_ready);
endinterface

// File: rtl/adc_result_reg.sv
// Valid/ready result register; flags results overwritten before the host took them.
module adc_result_reg
   import adc_flash_seq_pkg::*;
#(
   parameter int unsigned MAX_AVG_LOG2 = 3
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                pub,
   input  logic [CODE_W-1:0]                   pub_code,
   input  logic [acc_width(MAX_AVG_LOG2)-1:0]  pub_sum,
   input  logic                                clr_flags,
   output logic                                overrun,
   adc_flash_seq_if.master                     res
);

   // A publish overwrites; it is an overrun only if the old result is not being accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res.out_code  <= '0;
         res.out_sum   <= '0;
         res.out_valid <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         if (pub) begin
            res.out_code  <= pub_code;
            res.out_sum   <= pub_sum;
            res.out_valid <= 1'b1;
         end else if (res.out_valid && res.out_ready) begin
            res.out_valid <= 1'b0;
         end

         if (pub && res.out_valid && !res.out_ready) begin
            overrun <= 1'b1;
         end else if (clr_flags) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/adc_flash_seq.sv
// Conversion sequencer for the 3-bit flash ADC: sample/convert/capture,
// pair consistency check, 2^n averaging, single-shot or periodic bursts.
module adc_flash_seq
   import adc_flash_seq_pkg::*;
#(
   parameter int unsigned SAMP_CYC     = 2,
   parameter int unsigned TIMEOUT_CYC  = 16,
   parameter int unsigned MAX_AVG_LOG2 = 3,
   parameter int unsigned PERIOD_W     = 16
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic                                     enable,
   input  logic                                     start,
   input  logic                                     continuous,
   input  logic [PERIOD_W-1:0]                      period,
   input  logic [avg_sel_width(MAX_AVG_LOG2)-1:0]   avg_log2,
   input  logic                                     clr_flags,
   output logic                                     adc_samp,
   input  logic                                     adc_eoc,
   input  logic [CODE_W-1:0]                        adc_b,
   input  logic [CODE_W-1:0]                        adc_bn,
   output logic                                     busy,
   output logic                                     mismatch,
   output logic                                     overrun,
   output logic                                     timeout,
   adc_flash_seq_if.master                          res
);

   localparam int unsigned ACC_W = acc_width(MAX_AVG_LOG2);
   localparam int unsigned AVG_W = avg_sel_width(MAX_AVG_LOG2);
   localparam int unsigned CNT_W = MAX_AVG_LOG2 + 1;
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);
   localparam int unsigned SMP_W = 8;

   localparam logic [SMP_W-1:0] SAMP_LAST = SMP_W'(SAMP_CYC - 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

   state_t              state;
   logic [SMP_W-1:0]    samp_cnt;
   logic [TMO_W-1:0]    tmo_cnt;
   logic [CNT_W-1:0]    smp_cnt;
   logic [ACC_W-1:0]    acc;
   logic [PERIOD_W-1:0] per_cnt;
   logic [AVG_W-1:0]    avg_sel;
   logic [CODE_W-1:0]   cap_b;
   logic [CODE_W-1:0]   cap_bn;

   logic [ACC_W-1:0]    acc_sum_c;
   logic [CNT_W-1:0]    cnt_inc_c;
   logic                last_c;
   logic [CODE_W-1:0]   code_c;
   logic                pub_c;
   logic                mis_set_c;
   logic                tmo_set_c;
   logic [PERIOD_W-1:0] per_load_c;
   logic [AVG_W-1:0]    avg_clamp_c;
   logic                rearm_c;

   // Capture-cycle arithmetic and flag set conditions.
   always_comb begin
      acc_sum_c   = acc + ACC_W'(cap_b);
      cnt_inc_c   = smp_cnt + CNT_W'(1);
      last_c      = (cnt_inc_c == (CNT_W'(1) << avg_sel));
      code_c      = CODE_W'(acc_sum_c >> avg_sel);
      pub_c       = enable && (state == CAPTURE) && last_c;
      mis_set_c   = enable && (state == CAPTURE) && (cap_b != cap_bn);
      tmo_set_c   = enable && (state == CONVERT) && !adc_eoc && (tmo_cnt == TMO_LAST);
      per_load_c  = (period == '0) ? '0 : period - PERIOD_W'(1);
      avg_clamp_c = (32'(avg_log2) > MAX_AVG_LOG2) ? AVG_W'(MAX_AVG_LOG2) : avg_log2;
      rearm_c     = (per_cnt == '0);
   end

   // Sequencer FSM with registered adc_samp/busy; a burst start reloads the period counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         samp_cnt <= '0;
         tmo_cnt  <= '0;
         smp_cnt  <= '0;
         acc      <= '0;
         per_cnt  <= '0;
         avg_sel  <= '0;
         cap_b    <= '0;
         cap_bn   <= '0;
         adc_samp <= 1'b0;
         busy     <= 1'b0;
         mismatch <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         if (per_cnt != '0) begin
            per_cnt <= per_cnt - PERIOD_W'(1);
         end

         if (mis_set_c) begin
            mismatch <= 1'b1;
         end else if (clr_flags) begin
            mismatch <= 1'b0;
         end

         if (tmo_set_c) begin
            timeout <= 1'b1;
         end else if (clr_flags) begin
            timeout <= 1'b0;
         end

         if (!enable) begin
            state    <= IDLE;
            adc_samp <= 1'b0;
            busy     <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     state    <= SAMPLE;
                     adc_samp <= 1'b1;
                     busy     <= 1'b1;
                     acc      <= '0;
                     smp_cnt  <= '0;
                     samp_cnt <= '0;
                     per_cnt  <= per_load_c;
                     avg_sel  <= avg_clamp_c;
                  end
               end

               SAMPLE: begin
                  if (samp_cnt == SAMP_LAST) begin
                     state    <= CONVERT;
                     adc_samp <= 1'b0;
                     tmo_cnt  <= '0;
                  end else begin
                     samp_cnt <= samp_cnt + SMP_W'(1);
                  end
               end

               CONVERT: begin
                  if (adc_eoc) begin
                     state  <= CAPTURE;
                     cap_b  <= adc_b;
                     cap_bn <= adc_bn;
                  end else if (tmo_cnt == TMO_LAST) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     tmo_cnt <= tmo_cnt + TMO_W'(1);
                  end
               end

               CAPTURE: begin
                  acc     <= acc_sum_c;
                  smp_cnt <= cnt_inc_c;
                  if (!last_c) begin
                     state    <= SAMPLE;
                     adc_samp <= 1'b1;
                     samp_cnt <= '0;
                  end else if (!continuous) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else if (rearm_c) begin
                     // Burst outlasted the period: restart without a WAIT cycle.
                     state    <= SAMPLE;
                     adc_samp <= 1'b1;
                     acc      <= '0;
                     smp_cnt  <= '0;
                     samp_cnt <= '0;
                     per_cnt  <= per_load_c;
                  end else begin
                     state <= WAIT;
                  end
               end

               WAIT: begin
                  if (!continuous) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else if (rearm_c) begin
                     state    <= SAMPLE;
                     adc_samp <= 1'b1;
                     acc      <= '0;
                     smp_cnt  <= '0;
                     samp_cnt <= '0;
                     per_cnt  <= per_load_c;
                  end
               end

               default: begin
                  state    <= IDLE;
                  adc_samp <= 1'b0;
                  busy     <= 1'b0;
               end
            endcase
         end
      end
   end

   adc_result_reg #(
      .MAX_AVG_LOG2 (MAX_AVG_LOG2)
   ) u_result_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .pub       (pub_c),
      .pub_code  (code_c),
      .pub_sum   (acc_sum_c),
      .clr_flags (clr_flags),
      .overrun   (overrun),
      .res       (res)
   );

endmodule

// File: tb/tb_adc_flash_seq.sv
// Scoreboard bench for adc_flash_seq with a simple flash ADC response model.
module tb_adc_flash_seq;
   import adc_flash_seq_pkg::*;

   localparam int unsigned SAMP_CYC     = 2;
   localparam int unsigned TIMEOUT_CYC  = 16;
   localparam int unsigned MAX_AVG_LOG2 = 3;
   localparam int unsigned PERIOD_W     = 16;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b1;
   logic                  enable = 1'b1;
   logic                  start = 1'b0;
   logic                  continuous = 1'b0;
   logic [PERIOD_W-1:0]   period = '0;
   logic [1:0]            avg_log2 = '0;
   logic                  clr_flags = 1'b0;
   logic                  adc_samp;
   logic                  adc_eoc;
   logic [2:0]            adc_b;
   logic [2:0]            adc_bn;
   logic                  busy;
   logic                  mismatch;
   logic                  overrun;
   logic                  timeout;

   adc_flash_seq_if #(.MAX_AVG_LOG2(MAX_AVG_LOG2)) res_if ();

   adc_flash_seq #(
      .SAMP_CYC     (SAMP_CYC),
      .TIMEOUT_CYC  (TIMEOUT_CYC),
      .MAX_AVG_LOG2 (MAX_AVG_LOG2),
      .PERIOD_W     (PERIOD_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .start      (start),
      .continuous (continuous),
      .period     (period),
      .avg_log2   (avg_log2),
      .clr_flags  (clr_flags),
      .adc_samp   (adc_samp),
      .adc_eoc    (adc_eoc),
      .adc_b      (adc_b),
      .adc_bn     (adc_bn),
      .busy       (busy),
      .mismatch   (mismatch),
      .overrun    (overrun),
      .timeout    (timeout),
      .res        (res_if.master)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
   endtask

   // ADC model: eoc for one cycle on the first edge after Samp falls; codes from a list.
   logic       eoc_en = 1'b1;
   logic       samp_q = 1'b0;
   logic [5:0] code_mem [0:63];
   int         rd_idx = 0;
   int         wr_idx = 0;
   int         cyc = 0;

   assign adc_eoc = eoc_en && samp_q && !adc_samp;
   assign adc_b   = code_mem[rd_idx][5:3];
   assign adc_bn  = code_mem[rd_idx][2:0];

   // Scoreboard and output monitor.
   logic [8:0] exp_q [$];
   int         rise_q [$];
   logic       vld_q = 1'b0;
   logic       acc_q = 1'b0;
   logic [8:0] data_q = '0;
   logic       samp_n = 1'b0;
   logic [8:0] e;

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      samp_q <= adc_samp;
      if (adc_eoc) rd_idx <= rd_idx + 1;
      vld_q  <= res_if.out_valid;
      acc_q  <= res_if.out_valid && res_if.out_ready;
      data_q <= {res_if.out_code, res_if.out_sum};
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (adc_samp && !samp_n) rise_q.push_back(cyc);
         samp_n = adc_samp;
         if (res_if.out_valid &&
             (!vld_q || acc_q || ({res_if.out_code, res_if.out_sum} != data_q))) begin
            check("sb_expected_result", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("out_code", 32'(res_if.out_code), 32'(e[8:6]));
               check("out_sum", 32'(res_if.out_sum), 32'(e[5:0]));
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_code(input logic [2:0] b, input logic [2:0] bn);
      code_mem[wr_idx] = {b, bn};
      wr_idx++;
   endtask

   task automatic expect_res(input logic [2:0] code, input logic [5:0] sum);
      exp_q.push_back({code, sum});
   endtask

   // Leaves the bench at the negedge of cycle 1 (start sampled at edge 1).
   task automatic pulse_start();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_flags = 1'b1;
      step(1);
      clr_flags = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc);
      for (int i = 0; i < max_cyc && busy; i++) step(1);
      check("wait_idle_busy", 32'(busy), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_samp"}, 32'(adc_samp), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_valid"}, 32'(res_if.out_valid), 32'd0);
      check({tag, "_code"}, 32'(res_if.out_code), 32'd0);
      check({tag, "_sum"}, 32'(res_if.out_sum), 32'd0);
      check({tag, "_mismatch"}, 32'(mismatch), 32'd0);
      check({tag, "_overrun"}, 32'(overrun), 32'd0);
      check({tag, "_timeout"}, 32'(timeout), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 64; i++) code_mem[i] = '0;
      res_if.out_ready = 1'b1;
      #1 rst_n = 1'b0;
      step(2);
      check_all_zero("reset");
      rst_n = 1'b1;
      step(2);

      // Single shot, avg 1: samp cycles 1..2, valid at cycle 5.
      push_code(3'd5, 3'd5);
      expect_res(3'd5, 6'd5);
      rise_q.delete();
      pulse_start();
      check("t1_samp_c1", 32'(adc_samp), 32'd1);
      check("t1_busy_c1", 32'(busy), 32'd1);
      step(1);
      check("t1_samp_c2", 32'(adc_samp), 32'd1);
      step(1);
      check("t1_samp_c3", 32'(adc_samp), 32'd0);
      step(1);
      check("t1_valid_c4", 32'(res_if.out_valid), 32'd0);
      step(1);
      check("t1_valid_c5", 32'(res_if.out_valid), 32'd1);
      check("t1_busy_c5", 32'(busy), 32'd0);
      check("t1_flags", 32'({mismatch, overrun, timeout}), 32'd0);
      check("t1_samp_pulses", 32'(rise_q.size()), 32'd1);
      step(2);

      // Average of four: 3+4+4+6 = 17, code 17>>2 = 4.
      avg_log2 = 2'd2;
      push_code(3'd3, 3'd3);
      push_code(3'd4, 3'd4);
      push_code(3'd4, 3'd4);
      push_code(3'd6, 3'd6);
      expect_res(3'd4, 6'd17);
      rise_q.delete();
      pulse_start();
      wait_idle(60);
      check("t2_samp_pulses", 32'(rise_q.size()), 32'd4);
      avg_log2 = 2'd0;
      step(2);

      // Inconsistent pair: flag set, B value used; clear, then set-wins.
      push_code(3'd3, 3'd2);
      expect_res(3'd3, 6'd3);
      pulse_start();
      step(4);
      check("t3_mismatch_set", 32'(mismatch), 32'd1);
      pulse_clr();
      check("t3_mismatch_clr", 32'(mismatch), 32'd0);
      push_code(3'd3, 3'd2);
      expect_res(3'd3, 6'd3);
      pulse_start();
      step(3);
      clr_flags = 1'b1;
      step(1);
      clr_flags = 1'b0;
      check("t3_set_wins", 32'(mismatch), 32'd1);
      pulse_clr();
      check("t3_mismatch_clr2", 32'(mismatch), 32'd0);
      step(2);

      // No eoc: timeout after TIMEOUT_CYC cycles in CONVERT (cycle 19).
      eoc_en = 1'b0;
      pulse_start();
      step(17);
      check("t4_timeout_c18", 32'(timeout), 32'd0);
      check("t4_busy_c18", 32'(busy), 32'd1);
      step(1);
      check("t4_timeout_c19", 32'(timeout), 32'd1);
      check("t4_busy_c19", 32'(busy), 32'd0);
      check("t4_valid", 32'(res_if.out_valid), 32'd0);
      pulse_clr();
      check("t4_timeout_clr", 32'(timeout), 32'd0);

      // Enable dropped mid-CONVERT aborts the burst.
      pulse_start();
      step(4);
      check("t5_busy_convert", 32'(busy), 32'd1);
      enable = 1'b0;
      step(1);
      check("t5_busy_abort", 32'(busy), 32'd0);
      check("t5_samp_abort", 32'(adc_samp), 32'd0);
      enable = 1'b1;
      eoc_en = 1'b1;
      step(20);
      check("t5_no_timeout", 32'(timeout), 32'd0);
      start = 1'b1;
      enable = 1'b0;
      step(1);
      start = 1'b0;
      enable = 1'b1;
      check("t5_start_disabled", 32'(busy), 32'd0);
      step(2);
      check("t5_still_idle", 32'(busy), 32'd0);

      // Periodic bursts every 20 cycles with host stalled; then accept on publish.
      push_code(3'd1, 3'd1);
      push_code(3'd2, 3'd2);
      push_code(3'd3, 3'd3);
      expect_res(3'd1, 6'd1);
      expect_res(3'd2, 6'd2);
      expect_res(3'd3, 6'd3);
      continuous = 1'b1;
      period = 16'd20;
      res_if.out_ready = 1'b0;
      rise_q.delete();
      pulse_start();
      step(4);
      check("t6_valid_c5", 32'(res_if.out_valid), 32'd1);
      check("t6_overrun_c5", 32'(overrun), 32'd0);
      step(19);
      check("t6_overrun_c24", 32'(overrun), 32'd0);
      step(1);
      check("t6_overrun_c25", 32'(overrun), 32'd1);
      check("t6_code_latest", 32'(res_if.out_code), 32'd2);
      step(5);
      pulse_clr();
      check("t6_overrun_clr", 32'(overrun), 32'd0);
      step(13);
      res_if.out_ready = 1'b1;
      step(1);
      check("t6_no_overrun", 32'(overrun), 32'd0);
      check("t6_valid_c45", 32'(res_if.out_valid), 32'd1);
      check("t6_code_c45", 32'(res_if.out_code), 32'd3);
      continuous = 1'b0;
      wait_idle(40);
      check("t6_bursts", 32'(rise_q.size()), 32'd3);
      if (rise_q.size() == 3) begin
         check("t6_period_1", 32'(rise_q[1] - rise_q[0]), 32'd20);
         check("t6_period_2", 32'(rise_q[2] - rise_q[1]), 32'd20);
      end
      period = '0;
      step(2);

      // Reset mid-SAMPLE with a pending result and a set flag.
      res_if.out_ready = 1'b0;
      push_code(3'd6, 3'd7);
      expect_res(3'd6, 6'd6);
      pulse_start();
      wait_idle(20);
      check("t7_valid_held", 32'(res_if.out_valid), 32'd1);
      check("t7_mismatch", 32'(mismatch), 32'd1);
      pulse_start();
      check("t7_samp_before_rst", 32'(adc_samp), 32'd1);
      rst_n = 1'b0;
      #1;
      check_all_zero("t7_async_rst");
      step(1);
      rst_n = 1'b1;
      res_if.out_ready = 1'b1;
      step(2);
      check("t7_idle_after_rst", 32'(busy), 32'd0);
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/adc_flash_seq.md
# adc_flash_seq

Conversion sequencer for the 3-bit flash ADC logic block. Drives its `Samp` input, waits for its `eoc`, captures the differential code pair `B[2:0]`/`BN[2:0]`, checks that the pair is consistent, and optionally averages 2^n conversions. Results go to the host side through a valid/ready register. Sits between the flash ADC logic and the user-project register interface, in single-shot or free-running periodic mode.

## Interface
- `SAMP_CYC`, 2, cycles `samp` is held high per conversion (1..255)
- `TIMEOUT_CYC`, 16, max cycles in CONVERT waiting for `adc_eoc` (≥2)
- `MAX_AVG_LOG2`, 3, largest supported averaging exponent
- `PERIOD_W`, 16, width of the conversion-period counter
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `enable`  in  1  block enable; low aborts any activity
- `start`  in  1  single-cycle pulse, starts one burst (ignored unless IDLE)
- `continuous`  in  1  1 = restart bursts automatically every `period` cycles
- `period`  in  PERIOD_W  burst start-to-start interval in cycles; 0 = back-to-back
- `avg_log2`  in  clog2(MAX_AVG_LOG2+1)  burst length 2^avg_log2; values above MAX clamp to MAX
- `clr_flags`  in  1  pulse, clears sticky flags
- `adc_samp`  out  1  drives ADC `Samp`
- `adc_eoc`  in  1  ADC end of conversion
- `adc_b`  in  3  ADC `B[2:0]`
- `adc_bn`  in  3  ADC `BN[2:0]`
- `out_code`  out  3  averaged code
- `out_sum`  out  3+MAX_AVG_LOG2  raw burst sum
- `out_valid`  out  1  result available
- `out_ready`  in  1  host accepts result
- `busy`  out  1  FSM not IDLE
- `mismatch`  out  1  sticky: a captured pair had `adc_b != adc_bn`
- `overrun`  out  1  sticky: unaccepted result overwritten
- `timeout`  out  1  sticky: `adc_eoc` never arrived

## Operation
- FSM states: IDLE, SAMPLE, CONVERT, CAPTURE, WAIT.
- IDLE: `adc_samp`=0. Leaves on `start` && `enable`. Clears the accumulator and sample count, loads the period counter, latches clamped `avg_log2`.
- SAMPLE: `adc_samp`=1 for exactly SAMP_CYC cycles, then goes to CONVERT.
- CONVERT: `adc_samp`=0. Goes to CAPTURE in the cycle after `adc_eoc`=1 is sampled. If TIMEOUT_CYC cycles pass without it: set `timeout`, discard the burst, go to IDLE.
- CAPTURE: one cycle.
  - acc += `adc_b`; count++.
  - If `adc_b != adc_bn`: set `mismatch` (the `adc_b` value is still used).
  - If count < 2^avg_log2: go to SAMPLE.
  - Else publish the result: `out_sum`=acc, `out_code`=acc>>avg_log2 (truncating), `out_valid`=1. Then go to WAIT if `continuous`, else IDLE.
- WAIT: the period counter counts down from the burst start. At 0 (or if `period`=0), start a new burst by going to SAMPLE with acc/count cleared. If `continuous` drops, go to IDLE.
- Output register:
  - `out_valid` clears on `out_valid` && `out_ready`.
  - If a publish happens while `out_valid` && !`out_ready`: overwrite, set `overrun`.
  - Publish and accept in the same cycle: the new result is valid, no overrun.
- `enable` low in any state: next cycle IDLE, `adc_samp`=0, burst discarded. Output register and flags are kept.
- Sticky flags: cleared by `clr_flags`. If a set and a clear happen in the same cycle, set wins.
- `busy` = state != IDLE.

## Timing
- Reset values: `adc_samp`=0, `out_valid`=0, `out_code`=0, `out_sum`=0, `busy`=0, `mismatch`=`timeout`=`overrun`=0, FSM=IDLE, all counters 0.
- `start` at cycle 0 → `adc_samp` high cycles 1..SAMP_CYC.
- ADC asserts eoc on the first edge with Samp low, so `adc_eoc` is seen at cycle SAMP_CYC+1. CAPTURE is at cycle SAMP_CYC+2.
- With avg_log2=0, `out_valid` rises at cycle SAMP_CYC+3.
- Each extra burst sample adds SAMP_CYC+2 cycles.
- Period: the counter is loaded at the burst's first SAMPLE entry. If the burst is longer than `period`, the next burst starts right after CAPTURE (no WAIT cycle).
- `start` is ignored outside IDLE. `start` and `enable` falling in the same cycle: no burst.
- All outputs are registered.

## Structure
- Shared ADC package holds:
  - the FSM state enum;
  - the 3-bit code width constant;
  - the accumulator width function (3+MAX_AVG_LOG2).
- One natural sub-module: `adc_result_reg`, the valid/ready output register with overrun detection.
- The FSM, counters and accumulator stay in the top module.

## Test plan
- Single shot, avg_log2=0, ADC model returns B=BN=5 → `adc_samp` high 2 cycles; `out_valid` at cycle 5 with code 5, sum 5; `busy` low after; no flags.
- avg_log2=2, codes 3,4,4,6 → `out_sum`=17, `out_code`=4; `adc_samp` pulses 4 times.
- Capture with B=3, BN=2 → `mismatch`=1; result uses 3; `clr_flags` clears it; set and clear in the same cycle leaves it set.
- ADC model never raises eoc → `timeout`=1 at TIMEOUT_CYC cycles into CONVERT; FSM IDLE; `out_valid` stays 0.
- continuous=1, period=20, out_ready=0 → bursts start 20 cycles apart; second publish sets `overrun`, data = latest; out_ready=1 on the publish cycle → no overrun.
- `enable` dropped mid-CONVERT, and `rst_n` asserted mid-SAMPLE → `adc_samp` 0 next cycle / immediately; IDLE; reset values on every output.
